// File: rtl/md_sched_pkg.sv
// Shared types and constants for the MD cell-pair scheduler: FSM states,
// neighbour-offset encoding, shell sizes and the cell-index width helper.
package md_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    typedef struct packed {
        logic signed [1:0] dz;
        logic signed [1:0] dy;
        logic signed [1:0] dx;
    } offset_t;

    localparam int unsigned FULL_SHELL_CNT = 27;
    localparam int unsigned HALF_SHELL_CNT = 14;

    function automatic int unsigned cell_width(input int unsigned side);
        return 3 * $clog2(side);
    endfunction

    // Index 0..26 walks dz outer, dy middle, dx inner, each -1, 0, +1.
    // The half shell is exactly the tail of this order (indices 13..26).
    function automatic offset_t shell_offset(input logic [4:0] full_idx);
        offset_t     o;
        int unsigned f;
        f    = 32'(full_idx);
        o.dz = 2'(f / 9 - 1);
        o.dy = 2'((f % 9) / 3 - 1);
        o.dx = 2'(f % 3 - 1);
        return o;
    endfunction

endpackage

// File: rtl/md_wrap_coord.sv
// One grid axis: (coord + delta) mod 2**AW, delta in {-1, 0, +1}.
module md_wrap_coord #(
    parameter int unsigned AW = 2
) (
    input  logic [AW-1:0]     coord,
    input  logic signed [1:0] delta,
    output logic [AW-1:0]     wrapped
);

    // Power-of-two grid edge: plain truncating add gives periodic wrap.
    assign wrapped = coord + AW'(delta);

endmodule

// File: rtl/md_block_pair_scheduler.sv
// Walks every home cell and issues (home, neighbour) pair jobs under a credit limit.
// Build option: MD_HALF_SHELL_EN selects the 14-offset Newton half shell.
module md_block_pair_scheduler
    import md_sched_pkg::*;
#(
    parameter int unsigned BLOCK_SIDE      = 4,
    parameter int unsigned DENSITY         = 10,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pair_valid,
    input  logic                                 pair_ready,
    output logic [cell_width(BLOCK_SIDE)-1:0]    home_cell,
    output logic [cell_width(BLOCK_SIDE)-1:0]    nbr_cell,
    output logic                                 first_pair,
    output logic                                 last_pair,
    output logic [15:0]                          pair_atoms,
    input  logic                                 resp_valid,
    output logic [15:0]                          pairs_done,
    output logic                                 err_resp
);

    localparam int unsigned CW = cell_width(BLOCK_SIDE);
    localparam int unsigned AW = CW / 3;
`ifdef MD_HALF_SHELL_EN
    localparam int unsigned SHELL_CNT  = HALF_SHELL_CNT;
    localparam int unsigned SHELL_BASE = FULL_SHELL_CNT - HALF_SHELL_CNT;
`else
    localparam int unsigned SHELL_CNT  = FULL_SHELL_CNT;
    localparam int unsigned SHELL_BASE = 0;
`endif
    localparam logic [4:0] LAST_IDX = 5'(SHELL_CNT - 1);
    localparam logic [3:0] CREDITS  = 4'(MAX_OUTSTANDING);

    state_t        state_q, state_d;
    logic [CW-1:0] home_q, home_d;
    logic [4:0]    idx_q, idx_d;
    logic [CW-1:0] nbr_q, nbr_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    outst_q, outst_d;
    logic [15:0]   pairs_q, pairs_d;

    logic          xfer;
    logic          start_acc;
    logic          resp_ok;
    offset_t       off_d;
    logic [AW-1:0] nx, ny, nz;

    assign xfer      = valid_q && pair_ready;
    assign start_acc = (state_q == IDLE) && start;
    assign resp_ok   = resp_valid && (outst_q != 4'd0);

    always_comb begin
        state_d = state_q;
        home_d  = home_q;
        idx_d   = idx_q;
        done_d  = done_q;
        err_d   = err_q;
        outst_d = outst_q;
        pairs_d = pairs_q;

        case ({xfer, resp_ok})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
        if (resp_ok) begin
            pairs_d = pairs_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    pairs_d = '0;
                    home_d  = '0;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        home_d = home_q + 1'b1;
                        if (home_q == '1) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (outst_d == 4'd0) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (resp_valid && (outst_q == 4'd0)) begin
            err_d = 1'b1;
        end
        if (state_d == FINISH) begin
            done_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with the walk.
    always_comb begin
        valid_d = (state_d == ISSUE) && (outst_d < CREDITS);
        busy_d  = (state_d == ISSUE) || (state_d == DRAIN);
        off_d   = shell_offset(5'(idx_d + 5'(SHELL_BASE)));
        nbr_d   = nbr_q;
        first_d = first_q;
        last_d  = last_q;
        if (start_acc || xfer) begin
            nbr_d   = {nz, ny, nx};
            first_d = (idx_d == 5'd0);
            last_d  = (idx_d == LAST_IDX);
        end
    end

    md_wrap_coord #(.AW(AW)) u_wrap_x (
        .coord   (home_d[AW-1:0]),
        .delta   (off_d.dx),
        .wrapped (nx)
    );

    md_wrap_coord #(.AW(AW)) u_wrap_y (
        .coord   (home_d[2*AW-1:AW]),
        .delta   (off_d.dy),
        .wrapped (ny)
    );

    md_wrap_coord #(.AW(AW)) u_wrap_z (
        .coord   (home_d[3*AW-1:2*AW]),
        .delta   (off_d.dz),
        .wrapped (nz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            home_q  <= '0;
            idx_q   <= '0;
            nbr_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            outst_q <= '0;
            pairs_q <= '0;
        end else begin
            state_q <= state_d;
            home_q  <= home_d;
            idx_q   <= idx_d;
            nbr_q   <= nbr_d;
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            outst_q <= outst_d;
            pairs_q <= pairs_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pair_valid = valid_q;
    assign home_cell  = home_q;
    assign nbr_cell   = nbr_q;
    assign first_pair = first_q;
    assign last_pair  = last_q;
    assign pair_atoms = 16'(DENSITY * DENSITY);
    assign pairs_done = pairs_q;
    assign err_resp   = err_q;

endmodule

// File: tb/tb_md_block_pair_scheduler.sv
// Directed bench for md_block_pair_scheduler at default parameters.
module tb_md_block_pair_scheduler;

    localparam int S  = 4;
    localparam int NC = S * S * S;
`ifdef MD_HALF_SHELL_EN
    localparam int PER       = 14;
    localparam int FIRST_NBR = 0;
`else
    localparam int PER       = 27;
    localparam int FIRST_NBR = 63;
`endif
    localparam int TOTAL = NC * PER;

    logic        clk = 1'b0;
    logic        reset, start, pair_ready, resp_valid;
    logic        busy, done, pair_valid, first_pair, last_pair, err_resp;
    logic [5:0]  home_cell, nbr_cell;
    logic [15:0] pair_atoms, pairs_done;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;
    bit auto_resp = 1'b0;
    int exp_home [TOTAL];
    int exp_nbr  [TOTAL];
    bit exp_first[TOTAL];
    bit exp_last [TOTAL];

    md_block_pair_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .home_cell  (home_cell),
        .nbr_cell   (nbr_cell),
        .first_pair (first_pair),
        .last_pair  (last_pair),
        .pair_atoms (pair_atoms),
        .resp_valid (resp_valid),
        .pairs_done (pairs_done),
        .err_resp   (err_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks any transfer taking place at the coming edge against the table.
    task automatic step();
        logic x;
        x = pair_valid && pair_ready;
        if (x) begin
            chk("pair_in_range", 64'(k < TOTAL), 64'd1);
            if (k < TOTAL)
                chk($sformatf("pair%0d", k),
                    {home_cell, nbr_cell, first_pair, last_pair},
                    {6'(exp_home[k]), 6'(exp_nbr[k]), exp_first[k], exp_last[k]});
            k++;
        end
        tick();
        if (auto_resp) resp_valid = x;
    endtask

    initial begin
        int n, c, cyc, k0;
        bit sp;
        logic [13:0] snap;

        n = 0;
        for (int h = 0; h < NC; h++) begin
            c = 0;
            for (int dz = -1; dz <= 1; dz++)
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
`ifdef MD_HALF_SHELL_EN
                        if (!(dz > 0 || (dz == 0 && dy > 0) || (dz == 0 && dy == 0 && dx >= 0)))
                            continue;
`endif
                        exp_home[n]  = h;
                        exp_nbr[n]   = ((h / 16 + dz + S) % S) * S * S
                                     + (((h / 4) % 4 + dy + S) % S) * S
                                     + ((h % 4 + dx + S) % S);
                        exp_first[n] = (c == 0);
                        exp_last[n]  = (c == PER - 1);
                        c++;
                        n++;
                    end
        end

        reset = 1'b1; start = 1'b0; pair_ready = 1'b1; resp_valid = 1'b0;
        repeat (2) tick();
        chk("rst_flags", {busy, done, pair_valid, first_pair, last_pair, err_resp}, 0);
        chk("rst_home", home_cell, 0);
        chk("rst_nbr", nbr_cell, 0);
        chk("rst_pairs_done", pairs_done, 0);
        chk("pair_atoms", pair_atoms, 100);
        #2 reset = 1'b0;
        tick();
        chk("idle_valid", pair_valid, 0);

        // Full sweep, one response per transfer a cycle later, stray start mid-run
        start = 1'b1; tick(); start = 1'b0;
        chk("start_valid", pair_valid, 1);
        chk("start_busy", busy, 1);
        chk("start_first", first_pair, 1);
        chk("start_nbr", nbr_cell, FIRST_NBR);
        auto_resp = 1'b1; sp = 1'b0; cyc = 0;
        while (!done && cyc < 20000) begin
            if (k == 100 && !sp) begin start = 1'b1; sp = 1'b1; end
            else start = 1'b0;
            step();
            cyc++;
        end
        start = 1'b0;
        chk("sweep_done", done, 1);
        chk("sweep_count", k, TOTAL);
        chk("sweep_pairs_done", pairs_done, TOTAL);
        chk("sweep_err", err_resp, 0);
        chk("sweep_busy", busy, 0);
        tick();
        chk("done_held", done, 1);

        // Stray response in IDLE
        auto_resp = 1'b0;
        resp_valid = 1'b1; tick(); resp_valid = 1'b0;
        chk("err_set", err_resp, 1);
        chk("err_pairs_hold", pairs_done, TOTAL);

        // Credit throttle with no responses
        k = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("err_clear", err_resp, 0);
        chk("done_clear", done, 0);
        chk("pairs_clear", pairs_done, 0);
        k0 = k;
        repeat (10) step();
        chk("credit_limit", k - k0, 4);
        chk("credit_stall", pair_valid, 0);
        resp_valid = 1'b1; step(); resp_valid = 1'b0;
        k0 = k;
        repeat (6) step();
        chk("credit_one_more", k - k0, 1);
        resp_valid = 1'b1; repeat (4) step(); resp_valid = 1'b0;
        auto_resp = 1'b1;

        // Back-pressure: payload must hold while not accepted
        cyc = 0;
        while (!(k >= 50 && pair_valid) && cyc < 2000) begin step(); cyc++; end
        snap = {home_cell, nbr_cell, first_pair, last_pair};
        pair_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_payload", {home_cell, nbr_cell, first_pair, last_pair}, snap);
            chk("stall_valid", pair_valid, 1);
        end
        pair_ready = 1'b1;

        // Asynchronous abort on pair 500
        cyc = 0;
        while (k < 500 && cyc < 5000) begin step(); cyc++; end
        chk("reach_500", k, 500);
        auto_resp = 1'b0; resp_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst", {busy, done, pair_valid, first_pair, last_pair, err_resp,
                          home_cell, nbr_cell, pairs_done}, 0);
        #2 reset = 1'b0;
        tick();
        chk("post_rst_idle", {busy, pair_valid}, 0);
        k = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_valid", pair_valid, 1);
        chk("restart_home", home_cell, 0);
        chk("restart_nbr", nbr_cell, FIRST_NBR);
        chk("restart_first", first_pair, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/md_block_pair_scheduler.md
Name: md_block_pair_scheduler

Overview:
Sequencer for the molecular-dynamics force datapath. On start it walks every home cell of the BLOCK_SIDE^3 cell grid and issues (home, neighbour) cell-pair jobs to the force-compute pipeline over a valid/ready handshake. Neighbour coordinates wrap periodically. An outstanding-job credit counter throttles issue, and done is raised once every issued pair has been acknowledged.

Parameters:
BLOCK_SIDE, 4, cells per grid edge; must be a power of 2, at least 2.
DENSITY, 10, atoms per cell; passed through to the pair_atoms output only.
MAX_OUTSTANDING, 4, maximum pairs issued but not yet acknowledged; range 1..15.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  high after a completed sweep; held until the next accepted start or reset.
pair_valid  out  1  pair job offered.
pair_ready  in  1  datapath accepts the job.
home_cell  out  CW  home cell index z*S^2+y*S+x, where CW = 3*log2(BLOCK_SIDE).
nbr_cell  out  CW  neighbour cell index, wrapped.
first_pair  out  1  first pair of this home cell; datapath clears its force accumulator.
last_pair  out  1  final pair of this home cell; datapath writes back forces.
pair_atoms  out  16  DENSITY*DENSITY, constant.
resp_valid  in  1  one pair completed by the datapath.
pairs_done  out  16  count of acknowledged responses in the current sweep.
err_resp  out  1  sticky: resp_valid arrived while outstanding==0; cleared by the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, pair_valid=0, home_cell=0, nbr_cell=0, first_pair=0, last_pair=0, pairs_done=0, err_resp=0. Internal state: outstanding=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE, start=1 -> ISSUE. Same edge: clear done, pairs_done, err_resp; home=0, offset index=0.
- pair_valid rises the cycle after start is accepted.
- Offset order: dz outer, dy middle, dx inner, each stepping -1, 0, +1. That gives 27 offsets; first_pair marks index 0, last_pair marks index 26.
- Neighbour coordinate = (c + d) mod BLOCK_SIDE on each axis, computed with a CW/3-bit wrap add.
- Handshake: a transfer occurs when pair_valid && pair_ready. While pair_valid=1 and pair_ready=0, all payload outputs hold stable.
- pair_valid=1 only in ISSUE and only when outstanding < MAX_OUTSTANDING. When the limit is reached it deasserts without advancing the walk.
- outstanding: +1 on transfer, -1 on resp_valid. Both in the same cycle leaves it unchanged. resp_valid with outstanding==0 sets err_resp and leaves the counter at 0.
- pairs_done increments on every resp_valid that decrements outstanding.
- The transfer of the last offset of the last home cell -> DRAIN; pair_valid=0 from the next cycle.
- DRAIN: when outstanding==0, including a final resp_valid arriving this cycle -> FINISH.
- FINISH: done=1, busy=0 -> IDLE next cycle.
- start asserted outside IDLE is ignored.
- reset mid-sweep aborts immediately to reset values; in-flight responses are the datapath's responsibility.
- Total pairs per sweep = BLOCK_SIDE^3 * 27 (1728 at default).

Optional Feature:
MD_HALF_SHELL_EN
- Defined: Newton's-third-law half shell. Only offsets with (dz>0) or (dz=0, dy>0) or (dz=dy=0, dx>=0) are issued, in the same order: 14 per cell, first offset (0,0,-1)… Correction: the first offset is (dz,dy,dx)=(0,0,0) and the last is (1,1,1). Total at default = 896.
- Undefined: full 27-offset shell.

Decomposition:
- Package md_sched_pkg: FSM state enum; offset ROM typedef (3x signed 2-bit); constants for full and half shell offset counts (27/14); cell-index width function.
- One sub-module: md_wrap_coord, a combinational per-axis coordinate+offset modulo BLOCK_SIDE. Instantiated three times.

Test Plan:
- Default params, pair_ready=1, resp_valid = transfer delayed 1 cycle -> first pair home=0, nbr=63 with first_pair=1; second nbr=60; third nbr=61; 27th nbr=21 with last_pair=1; pairs_done ends at 1728; done=1, err_resp=0.
- pair_ready=1, resp_valid=0 held -> exactly 4 transfers, then pair_valid=0. One resp_valid pulse -> exactly one more transfer.
- pair_ready low for 5 cycles mid-sweep -> home_cell, nbr_cell, first_pair and last_pair stable across all 5 cycles; no pair skipped or duplicated.
- start pulsed during ISSUE -> ignored; total still 1728. resp_valid pulsed in IDLE -> err_resp=1, cleared by the next start.
- reset asserted on pair 500 -> all outputs at reset values asynchronously; a new start restarts at home=0, nbr=63.
- MD_HALF_SHELL_EN defined -> first pair home=0, nbr=0; 14 pairs per cell; pairs_done=896 at done.
